uart_frame_parser: RTL and testbench

- Downstream consumer of the UART controller read path.
- Pulls received bytes one at a time through the controller's read request/valid interface and locates framed packets in the byte stream.
- Checks each frame and presents its payload as 32-bit words, with a valid/ready handshake, to the systolic-array load logic.
- Reports each frame's command, length and pass/fail status.

---
 rtl/uart_frame_parser.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Pulls UART bytes through a one-deep read handshake and parses SYNC/CMD/LEN/payload/CHK frames into 32-bit words.
// Latency: word_valid rises one cycle after its 4th byte is taken; while a word is stalled no bytes are fetched and the idle timer freezes.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_WORDS     = 64,
    parameter int         REQ_TIMEOUT   = 16,
    parameter int         FRAME_TIMEOUT = 1_250_000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        byte_read,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [7:0]  cmd,
    output logic [7:0]  len,
    output logic        cmd_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [7:0]  err_count
);
    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;

    localparam int REQ_W  = $clog2(REQ_TIMEOUT + 1);
    localparam int IDLE_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [REQ_W-1:0]  REQ_LAST  = REQ_W'(REQ_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FRAME_TIMEOUT - 1);
    localparam logic [7:0]        MAX_LEN   = 8'(MAX_WORDS);

    logic [2:0]        state;
    logic              rd_pend;
    logic [REQ_W-1:0]  req_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        chk_acc;
    logic [7:0]        word_cnt;
    logic [1:0]        byte_idx;

    logic stall;
    logic byte_acc;
    logic req_expire;
    logic issue;
    logic frame_to;
    logic err_inc;

    // A byte returned in the same cycle as its own request pulse is not taken.
    assign stall      = word_valid & ~word_ready;
    assign byte_acc   = rd_pend & ~byte_read & byte_valid;
    assign req_expire = rd_pend & ~byte_acc & (req_cnt == REQ_LAST);
    assign issue      = (~rd_pend | req_expire) & ~stall;
    assign frame_to   = (state != ST_HUNT) & ~byte_acc & ~stall & (idle_cnt == IDLE_LAST);
    assign err_inc    = frame_to
                      | (byte_acc & (state == ST_LEN)   & (byte_in > MAX_LEN))
                      | (byte_acc & (state == ST_CHECK) & (byte_in != chk_acc));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_read <= 1'b0;
            rd_pend   <= 1'b0;
            req_cnt   <= '0;
        end else if (issue) begin
            byte_read <= 1'b1;
            rd_pend   <= 1'b1;
            req_cnt   <= '0;
        end else begin
            byte_read <= 1'b0;
            if (byte_acc || req_expire) begin
                rd_pend <= 1'b0;
            end else if (rd_pend) begin
                req_cnt <= req_cnt + REQ_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_HUNT;
            cmd        <= '0;
            len        <= '0;
            cmd_valid  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            chk_acc    <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            idle_cnt   <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
                word_last  <= 1'b0;
            end

            if (byte_acc) begin
                idle_cnt <= IDLE_W'(1);
            end else if (state == ST_HUNT) begin
                idle_cnt <= '0;
            end else if (!stall) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (frame_to) begin
                state      <= ST_HUNT;
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                word_valid <= 1'b0;
                word_last  <= 1'b0;
                idle_cnt   <= '0;
            end else if (byte_acc) begin
                case (state)
                    ST_HUNT: begin
                        if (byte_in == SYNC_BYTE) state <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd     <= byte_in;
                        chk_acc <= byte_in;
                        state   <= ST_LEN;
                    end
                    ST_LEN: begin
                        len <= byte_in;
                        if (byte_in > MAX_LEN) begin
                            frame_done <= 1'b1;
                            frame_ok   <= 1'b0;
                            state      <= ST_HUNT;
                        end else begin
                            cmd_valid <= 1'b1;
                            chk_acc   <= chk_acc ^ byte_in;
                            word_cnt  <= '0;
                            byte_idx  <= '0;
                            state     <= (byte_in == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        word_out[{byte_idx, 3'b000} +: 8] <= byte_in;
                        chk_acc  <= chk_acc ^ byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_valid <= 1'b1;
                            word_cnt   <= word_cnt + 8'd1;
                            if (word_cnt + 8'd1 == len) begin
                                word_last <= 1'b1;
                                state     <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        frame_done <= 1'b1;
                        frame_ok   <= (byte_in == chk_acc);
                        state      <= ST_HUNT;
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_inc && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: a one-cycle-latency byte source feeds hand-built frames,
// a negedge monitor logs cmd/word/frame events, and hand-computed values are compared through expect_eq.
module tb_uart_frame_parser;
    localparam int REQ_TO = 16;
    localparam int FT     = 40;
    localparam int MAXW   = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        byte_read;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic        cmd_valid;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        word_last;
    logic        frame_done;
    logic        frame_ok;
    logic [7:0]  err_count;

    always #5 clock = ~clock;

    uart_frame_parser #(
        .SYNC_BYTE    (8'hA5),
        .MAX_WORDS    (MAXW),
        .REQ_TIMEOUT  (REQ_TO),
        .FRAME_TIMEOUT(FT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .byte_read (byte_read),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .cmd       (cmd),
        .len       (len),
        .cmd_valid (cmd_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .word_last (word_last),
        .frame_done(frame_done),
        .frame_ok  (frame_ok),
        .err_count (err_count)
    );

    int vec_cnt = 0;
    int miscmp  = 0;

    logic [7:0]  tx_q[$];
    logic [15:0] cv_q[$];
    logic [32:0] wd_q[$];
    int          rd_cyc_q[$];
    int          cyc = 0;
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    int          rd_cnt = 0;
    int          unstable = 0;
    int          last_drive_cyc = 0;
    bit          resp_due = 1'b0;
    logic        wv_prev = 1'b0;
    logic        wr_prev = 1'b0;
    logic [31:0] wo_prev = '0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_frame(input string tag, input int start);
        int k;
        k = 0;
        while (fd_cnt == start && k < 400) begin
            step(1);
            k++;
        end
        expect_eq({tag, " frame_done"}, 32'(fd_cnt - start), 32'd1);
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [7:0] l,
                              input logic [7:0] first, input logic [7:0] chk);
        logic [7:0] b;
        b = first;
        tx_q.push_back(8'hA5);
        tx_q.push_back(c);
        tx_q.push_back(l);
        for (int i = 0; i < 4 * int'(l); i++) begin
            tx_q.push_back(b);
            b = b + 8'd1;
        end
        tx_q.push_back(chk);
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [31:0] w, input logic l);
        logic [32:0] got;
        got = 33'h1_FFFF_FFFF;
        if (idx < wd_q.size()) got = wd_q[idx];
        expect_eq({tag, " data"}, got[31:0], w);
        expect_eq({tag, " last"}, 32'(got[32]), 32'(l));
    endtask

    task automatic expect_cmd(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = 16'hFFFF;
        if (cv_q.size() > 0) got = cv_q[0];
        expect_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic clear_logs();
        cv_q.delete();
        wd_q.delete();
    endtask

    // Monitor and byte source share one negedge process so event order is fixed.
    initial begin
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        forever begin
            @(negedge clock);
            cyc++;
            if (cmd_valid) cv_q.push_back({cmd, len});
            if (word_valid && word_ready) wd_q.push_back({word_last, word_out});
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (byte_read) begin
                rd_cnt++;
                rd_cyc_q.push_back(cyc);
            end
            if (wv_prev && !wr_prev && word_valid && word_out != wo_prev) unstable++;
            wv_prev = word_valid;
            wr_prev = word_ready;
            wo_prev = word_out;
            byte_valid = 1'b0;
            if (reset) begin
                resp_due = 1'b0;
            end else begin
                if (resp_due && tx_q.size() > 0) begin
                    byte_valid     = 1'b1;
                    byte_in        = tx_q.pop_front();
                    last_drive_cyc = cyc;
                end
                resp_due = byte_read && (tx_q.size() > 0);
            end
        end
    end

    initial begin
        int start;
        int k;
        int rd0;
        int d1;
        int d2;

        reset      = 1'b1;
        word_ready = 1'b1;
        step(3);
        expect_eq("rst ctl", 32'({byte_read, cmd_valid, word_valid, word_last, frame_done, frame_ok}), 32'd0);
        expect_eq("rst word_out", word_out, 32'd0);
        expect_eq("rst cmd/len", 32'({cmd, len}), 32'd0);
        expect_eq("rst err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        step(2);

        // Good frame, CHK = 07^02^01^..^08 = 0D
        clear_logs();
        start = fd_cnt;
        push_frame(8'h07, 8'h02, 8'h01, 8'h0D);
        wait_frame("good", start);
        expect_eq("good cmd_valid count", 32'(cv_q.size()), 32'd1);
        expect_cmd("good cmd/len", 16'h0702);
        expect_eq("good word count", 32'(wd_q.size()), 32'd2);
        expect_word("good w0", 0, 32'h04030201, 1'b0);
        expect_word("good w1", 1, 32'h08070605, 1'b1);
        expect_eq("good frame_ok", 32'(frame_ok), 32'd1);
        expect_eq("good err_count", 32'(err_count), 32'd0);
        step(3);

        // Bad checksum
        clear_logs();
        start = fd_cnt;
        push_frame(8'h07, 8'h02, 8'h01, 8'h00);
        wait_frame("badchk", start);
        expect_eq("badchk word count", 32'(wd_q.size()), 32'd2);
        expect_word("badchk w0", 0, 32'h04030201, 1'b0);
        expect_word("badchk w1", 1, 32'h08070605, 1'b1);
        expect_eq("badchk frame_ok", 32'(frame_ok), 32'd0);
        expect_eq("badchk err_count", 32'(err_count), 32'd1);
        step(3);

        // Hunting through junk before a LEN=0 frame, CHK = 09^00 = 09
        clear_logs();
        start = fd_cnt;
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h3C);
        push_frame(8'h09, 8'h00, 8'h00, 8'h09);
        wait_frame("hunt", start);
        expect_eq("hunt cmd_valid count", 32'(cv_q.size()), 32'd1);
        expect_cmd("hunt cmd/len", 16'h0900);
        expect_eq("hunt word count", 32'(wd_q.size()), 32'd0);
        expect_eq("hunt frame_ok", 32'(frame_ok), 32'd1);
        expect_eq("hunt err_count", 32'(err_count), 32'd1);
        step(3);

        // Backpressure, payload 10..17, CHK = 11^02^10^..^17 = 13
        clear_logs();
        start      = fd_cnt;
        unstable   = 0;
        word_ready = 1'b0;
        push_frame(8'h11, 8'h02, 8'h10, 8'h13);
        k = 0;
        while (!word_valid && k < 200) begin
            step(1);
            k++;
        end
        expect_eq("bp word_valid rise", 32'(word_valid), 32'd1);
        rd0 = rd_cnt;
        step(50);
        expect_eq("bp byte_read during stall", 32'(rd_cnt - rd0), 32'd0);
        expect_eq("bp frame_done during stall", 32'(fd_cnt - start), 32'd0);
        expect_eq("bp word held", word_out, 32'h13121110);
        expect_eq("bp word_valid held", 32'(word_valid), 32'd1);
        expect_eq("bp word_out changes", 32'(unstable), 32'd0);
        word_ready = 1'b1;
        wait_frame("bp", start);
        expect_eq("bp word count", 32'(wd_q.size()), 32'd2);
        expect_word("bp w0", 0, 32'h13121110, 1'b0);
        expect_word("bp w1", 1, 32'h17161514, 1'b1);
        expect_eq("bp frame_ok", 32'(frame_ok), 32'd1);
        step(3);

        // LEN = MAX_WORDS+1 rejected immediately
        clear_logs();
        start = fd_cnt;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h41);
        wait_frame("maxlen", start);
        expect_eq("maxlen frame_ok", 32'(frame_ok), 32'd0);
        expect_eq("maxlen err_count", 32'(err_count), 32'd2);
        expect_eq("maxlen cmd_valid count", 32'(cv_q.size()), 32'd0);
        expect_eq("maxlen len", 32'(len), 32'h41);
        expect_eq("maxlen cmd", 32'(cmd), 32'h01);
        step(3);

        // Frame timeout after two payload bytes, then a good frame
        clear_logs();
        start = fd_cnt;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'hBB);
        wait_frame("timeout", start);
        expect_eq("timeout delay", 32'(fd_cyc - last_drive_cyc), 32'(FT));
        expect_eq("timeout frame_ok", 32'(frame_ok), 32'd0);
        expect_eq("timeout err_count", 32'(err_count), 32'd3);
        step(3);
        clear_logs();
        start = fd_cnt;
        push_frame(8'h07, 8'h02, 8'h01, 8'h0D);
        wait_frame("after timeout", start);
        expect_eq("after timeout frame_ok", 32'(frame_ok), 32'd1);
        expect_word("after timeout w1", 1, 32'h08070605, 1'b1);
        expect_eq("after timeout err_count", 32'(err_count), 32'd3);
        step(3);

        // Reset mid-payload
        clear_logs();
        start = fd_cnt;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h07);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h03);
        k = 0;
        while (tx_q.size() > 0 && k < 200) begin
            step(1);
            k++;
        end
        step(4);
        reset = 1'b1;
        #2;
        expect_eq("midrst ctl", 32'({byte_read, cmd_valid, word_valid, word_last, frame_done, frame_ok}), 32'd0);
        expect_eq("midrst word_out", word_out, 32'd0);
        expect_eq("midrst err_count", 32'(err_count), 32'd0);
        step(2);
        reset = 1'b0;
        tx_q.delete();
        step(10);
        expect_eq("midrst no frame_done", 32'(fd_cnt - start), 32'd0);
        clear_logs();
        start = fd_cnt;
        push_frame(8'h07, 8'h02, 8'h01, 8'h0D);
        wait_frame("after reset", start);
        expect_eq("after reset frame_ok", 32'(frame_ok), 32'd1);
        expect_cmd("after reset cmd/len", 16'h0702);
        expect_word("after reset w0", 0, 32'h04030201, 1'b0);
        step(3);

        // Empty FIFO polling
        rd_cyc_q.delete();
        step(80);
        expect_eq("poll pulses", 32'(rd_cyc_q.size() >= 4), 32'd1);
        d1 = -1;
        d2 = -1;
        if (rd_cyc_q.size() >= 3) begin
            d1 = rd_cyc_q[1] - rd_cyc_q[0];
            d2 = rd_cyc_q[2] - rd_cyc_q[1];
        end
        expect_eq("poll period a", 32'(d1), 32'(REQ_TO));
        expect_eq("poll period b", 32'(d2), 32'(REQ_TO));
        expect_eq("poll frame_ok held", 32'(frame_ok), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
